// File: rtl/line_clear_if.sv
// Bus bundle between the game controller and the line-clear engine.
interface line_clear_if #(
    parameter int ROWS    = 22,
    parameter int COLS    = 10,
    parameter int CW      = 3,
    parameter int SCORE_W = 8
);
    localparam int GW = ROWS * COLS * CW;
    localparam int LW = $clog2(ROWS + 1);

    logic              start;
    logic [GW-1:0]     grid_in;
    logic              busy;
    logic              done;
    logic [GW-1:0]     grid_out;
    logic [LW-1:0]     lines_cleared;
    logic [SCORE_W-1:0] score;

    modport master (
        output start, grid_in,
        input  busy, done, grid_out, lines_cleared, score
    );

    modport slave (
        input  start, grid_in,
        output busy, done, grid_out, lines_cleared, score
    );
endinterface

// File: rtl/line_clear_engine.sv
// Playfield line-clear and scoring engine: snapshots the grid, removes every
// full row bottom-up while compacting the rows above, then publishes the
// compacted grid, the cleared-line count and a saturating running score.
module line_clear_engine #(
    parameter int ROWS    = 22,
    parameter int COLS    = 10,
    parameter int CW      = 3,
    parameter int SCORE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    line_clear_if.slave bus
);
    localparam int RW  = COLS * CW;
    localparam int GW  = ROWS * RW;
    localparam int LW  = $clog2(ROWS + 1);
    localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      buf_q, buf_d;
    logic [GW-1:0]      grid_q, grid_d;
    logic [RIW-1:0]     row_q, row_d;
    logic [LW-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]      lines_q, lines_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic               row_full;
    logic [3:0]         pts;
    logic [SCORE_W:0]   score_sum;

    // Full-row detector for the buffer row under the scan pointer.
    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (buf_q[(int'(row_q) * COLS + c) * CW +: CW] == '0) row_full = 1'b0;
        end
    end

    // Points for this pass and the unclamped score sum (one spare bit flags overflow).
    always_comb begin
        if (cnt_q == LW'(0))      pts = 4'd0;
        else if (cnt_q == LW'(1)) pts = 4'd1;
        else if (cnt_q == LW'(2)) pts = 4'd3;
        else if (cnt_q == LW'(3)) pts = 4'd5;
        else                      pts = 4'd8;
        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(pts);
    end

    // Next-state and datapath updates for the scan/shift controller.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        buf_d   = buf_q;
        grid_d  = grid_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        lines_d = lines_q;
        score_d = score_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    buf_d   = bus.grid_in;
                    row_d   = RIW'(ROWS - 1);
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (row_full) begin
                    state_d = SHIFT;
                end else if (row_q != '0) begin
                    row_d = row_q - RIW'(1);
                end else begin
                    state_d = DONE;
                    grid_d  = buf_q;
                    lines_d = cnt_q;
                    score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                end
            end
            SHIFT: begin
                // Rows 1..r drop by one, row 0 empties; rows below r keep their contents.
                buf_d[0 +: RW] = '0;
                for (int i = 1; i < ROWS; i++) begin
                    if (i <= int'(row_q)) buf_d[i*RW +: RW] = buf_q[(i-1)*RW +: RW];
                end
                if (cnt_q != LW'(ROWS)) cnt_d = cnt_q + LW'(1);
                state_d = SCAN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any pass in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            // NOTE: the snapshot buffer is a plain register bank, so it is reset like any other flop.
            buf_q   <= '0;
            grid_q  <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            lines_q <= '0;
            score_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q <= state_d;
            buf_q   <= buf_d;
            grid_q  <= grid_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
            score_q <= score_d;
        end
    end

    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == DONE);
    assign bus.grid_out      = grid_q;
    assign bus.lines_cleared = lines_q;
    assign bus.score         = score_q;
endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench for line_clear_engine: a default-size instance and a
// 4x3x2 instance. Latency is the number of clock edges from the edge that
// samples start to the edge that samples done high.
module tb_line_clear_engine;
    localparam int ROWS = 22, COLS = 10, CW = 3, SW = 8;
    localparam int GW   = ROWS * COLS * CW;
    localparam int RS = 4, CS = 3, CWS = 2;
    localparam int GWS  = RS * CS * CWS;

    typedef struct {
        logic [GW-1:0] grid;
        int            lines;
        int            score;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_score = 0;
    int   exp_score_s = 0;
    int   acc_cyc = 0;
    int   acc_cyc_s = 0;
    exp_t sb_q[$];
    exp_t sbs_q[$];
    exp_t e_mon, e_mon_s;

    logic [GW-1:0] g_one, e_one, g_four, e_four, g_two, e_two;

    line_clear_if #(.ROWS(ROWS), .COLS(COLS), .CW(CW), .SCORE_W(SW)) bus ();
    line_clear_if #(.ROWS(RS), .COLS(CS), .CW(CWS), .SCORE_W(SW)) bus_s ();

    line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .CW(CW), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    line_clear_engine #(.ROWS(RS), .COLS(CS), .CW(CWS), .SCORE_W(SW)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pts(input int n);
        if (n == 0) return 0;
        if (n == 1) return 1;
        if (n == 2) return 3;
        if (n == 3) return 5;
        return 8;
    endfunction

    function automatic logic [GW-1:0] set_cell(input logic [GW-1:0] g, input int r, input int c,
                                               input logic [CW-1:0] v);
        g[(r*COLS + c)*CW +: CW] = v;
        return g;
    endfunction

    function automatic logic [GW-1:0] fill_row(input logic [GW-1:0] g, input int r, input logic [CW-1:0] v);
        for (int c = 0; c < COLS; c++) g = set_cell(g, r, c, v);
        return g;
    endfunction

    function automatic logic [GW-1:0] rand_grid();
        logic [GW-1:0] g;
        for (int k = 0; k < GW; k++) g[k] = 1'($urandom_range(0, 1));
        return g;
    endfunction

    // Main-instance monitor: track acceptance, compare every done against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.start && !bus.busy) acc_cyc = cyc;
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: done=1 with no pass outstanding (cycle %0d)", cyc);
                end else begin
                    e_mon = sb_q.pop_front();
                    check("grid_out", bus.grid_out, e_mon.grid);
                    check("lines_cleared", GW'(bus.lines_cleared), GW'(e_mon.lines));
                    check("score", GW'(bus.score), GW'(e_mon.score));
                    check("latency", GW'(cyc - acc_cyc), GW'(e_mon.lat));
                end
            end
        end
    end

    // Small-instance monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_s.start && !bus_s.busy) acc_cyc_s = cyc;
            if (bus_s.done) begin
                if (sbs_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done_small: done=1 with no pass outstanding (cycle %0d)", cyc);
                end else begin
                    e_mon_s = sbs_q.pop_front();
                    check("small_grid_out", GW'(bus_s.grid_out), e_mon_s.grid);
                    check("small_lines_cleared", GW'(bus_s.lines_cleared), GW'(e_mon_s.lines));
                    check("small_score", GW'(bus_s.score), GW'(e_mon_s.score));
                    check("small_latency", GW'(cyc - acc_cyc_s), GW'(e_mon_s.lat));
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && (sb_q.size() != 0 || sbs_q.size() != 0); i++) @(negedge clk);
        if (sb_q.size() != 0 || sbs_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: done not seen within 300 cycles", name);
            sb_q.delete();
            sbs_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic push_exp(input logic [GW-1:0] eg, input int lines, input int lat);
        exp_t e;
        exp_score = (exp_score + pts(lines) > 255) ? 255 : exp_score + pts(lines);
        e.grid = eg; e.lines = lines; e.score = exp_score; e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic run_pass(input string name, input logic [GW-1:0] g, input logic [GW-1:0] eg,
                            input int lines, input int lat);
        push_exp(eg, lines, lat);
        @(posedge clk); #1;
        bus.grid_in = g;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        wait_drain(name);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t es;
        logic [GWS-1:0] g_small;

        // Stimulus vectors with hand-computed results.
        g_one  = fill_row('0, 21, 3'b100);
        g_one  = set_cell(g_one, 20, 0, 3'b010);
        e_one  = set_cell('0, 21, 0, 3'b010);
        g_four = '0;
        for (int r = 18; r <= 21; r++) g_four = fill_row(g_four, r, 3'b001);
        g_four = set_cell(g_four, 17, 4, 3'b111);
        e_four = set_cell('0, 21, 4, 3'b111);
        g_two  = fill_row(fill_row('0, 21, 3'b101), 19, 3'b110);
        e_two  = '0;
        for (int c = 0; c < 5; c++) begin
            g_two = set_cell(g_two, 20, c, 3'b011);
            e_two = set_cell(e_two, 21, c, 3'b011);
        end

        rst = 1'b1;
        bus.start = 1'b0;   bus.grid_in = '0;
        bus_s.start = 1'b0; bus_s.grid_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset in the fifth SCAN cycle aborts the pass and clears everything.
        @(posedge clk); #1;
        bus.grid_in = g_one;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check("rst_busy", GW'(bus.busy), GW'(0));
        check("rst_done", GW'(bus.done), GW'(0));
        check("rst_grid_out", bus.grid_out, '0);
        check("rst_lines", GW'(bus.lines_cleared), GW'(0));
        check("rst_score", GW'(bus.score), GW'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_score = 0;

        run_pass("empty", '0, '0, 0, 23);
        run_pass("one_line", g_one, e_one, 1, 25);
        run_pass("four_lines", g_four, e_four, 4, 31);
        run_pass("split_two", g_two, e_two, 2, 27);

        // Bring the score to exactly 250 (12 + 29*8 + 2*3), then saturate.
        while (exp_score + 8 <= 250) run_pass("preload4", g_four, e_four, 4, 31);
        while (exp_score + 3 <= 250) run_pass("preload2", g_two, e_two, 2, 27);
        while (exp_score < 250)      run_pass("preload1", g_one, e_one, 1, 25);
        run_pass("saturate", g_four, e_four, 4, 31);
        run_pass("saturated_hold", g_one, e_one, 1, 25);

        // start held through a whole pass (including DONE) with grid_in scrambled while busy.
        push_exp(e_one, 1, 25);
        @(posedge clk); #1;
        bus.grid_in = g_one;
        bus.start   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.done) break;
            if (bus.busy) bus.grid_in = rand_grid();
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.grid_in = '0;
        wait_drain("held_start");
        repeat (40) @(negedge clk);

        // Small geometry, every row full.
        g_small = '1 & {GWS/2{2'b01}};
        exp_score_s = 8;
        es.grid = '0; es.lines = 4; es.score = exp_score_s; es.lat = 13;
        sbs_q.push_back(es);
        @(posedge clk); #1;
        bus_s.grid_in = g_small;
        bus_s.start   = 1'b1;
        @(posedge clk); #1;
        bus_s.start   = 1'b0;
        wait_drain("small_all_full");

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
